// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types and constants for the serial slice-by-slice magnitude comparator.
// Result constants are packed as {gt, lt, eq}.
package serial_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

endpackage

// File: rtl/comparator2bit.sv
// Combinational 2-bit magnitude comparator used for one operand slice per cycle.
module comparator2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator: walks 2-bit slices MSB-first and stops at the
// first unequal slice, reporting the result and the number of slices examined.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on the accepting edge
// COMPARE | one slice compared per cycle, MSB pair first
// DONE    | one-cycle done pulse, result valid; returns to IDLE
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   a_in,
  input  logic [WIDTH-1:0]                   b_in,
  output logic                               busy,
  output logic                               done,
  output logic                               a_gt_b,
  output logic                               a_lt_b,
  output logic                               a_eq_b,
  output logic [$clog2(WIDTH/2+1)-1:0]       cycles
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = $clog2(NSLICE + 1);
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [1:0]       a_sl;
  logic [1:0]       b_sl;
  logic             sl_gt;
  logic             sl_lt;
  logic             sl_eq;

  assign a_sl = a_q[{idx, 1'b0} +: 2];
  assign b_sl = b_q[{idx, 1'b0} +: 2];

  comparator2bit u_cmp (
    .a  (a_sl),
    .b  (b_sl),
    .gt (sl_gt),
    .lt (sl_lt),
    .eq (sl_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      a_eq_b <= 1'b0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            idx   <= IW'(NSLICE - 1);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          // Results stay at the previous values until this operation resolves.
          if (!sl_eq) begin
            {a_gt_b, a_lt_b, a_eq_b} <= {sl_gt, sl_lt, 1'b0};
            cycles <= cnt + CW'(1);
            done   <= 1'b1;
            state  <= DONE;
          end else if (idx != '0) begin
            idx <= idx - IW'(1);
            cnt <= cnt + CW'(1);
          end else begin
            {a_gt_b, a_lt_b, a_eq_b} <= EQ;
            cycles <= cnt + CW'(1);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl: stimulus pushes model predictions,
// a negedge monitor pops them whenever done is presented.
module tb_serial_compare_ctrl;

  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = $clog2(NSLICE + 1);

  typedef struct {
    logic [2:0] res;   // {gt, lt, eq}
    int         cyc;
    int         acc;
    int         a;
    int         b;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             busy, done, a_gt_b, a_lt_b, a_eq_b;
  logic [CW-1:0]    cycles;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b),
    .cycles (cycles)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer compare; slice count from the first differing base-4 digit.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.res = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
    e.cyc = NSLICE;
    for (int i = 0; i < NSLICE; i++) begin
      int sh = 2 * (NSLICE - 1 - i);
      if (((a >> sh) & 3) != ((b >> sh) & 3)) begin
        e.cyc = i + 1;
        break;
      end
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic issue(input int a, input int b, input bit hold, input bit perturb);
    exp_t e;
    wait_idle();
    a_in  = WIDTH'(a);
    b_in  = WIDTH'(b);
    start = 1'b1;
    e     = model(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = hold;
    if (perturb) begin
      a_in  = WIDTH'($urandom);
      b_in  = WIDTH'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = hold;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
    check({tag, "_gt"},     32'(a_gt_b), 32'd0);
    check({tag, "_lt"},     32'(a_lt_b), 32'd0);
    check({tag, "_eq"},     32'(a_eq_b), 32'd0);
    check({tag, "_cycles"}, 32'(cycles), 32'd0);
  endtask

  // Monitor
  initial begin
    bit   prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          check("done_one_cycle", 32'(done), 32'd0);
          check("busy_after_done", 32'(busy), 32'd0);
        end
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            check("result", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(e.res));
            check("cycles", 32'(cycles), 32'(e.cyc));
            check("latency", 32'(cyc - e.acc), 32'(e.cyc));
            check("busy_in_done", 32'(busy), 32'd1);
          end
        end
        prev_done = (done === 1'b1);
      end
    end
  end

  initial begin
    int t;
    int a, b;
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // First start accepted on the first edge after reset release.
    issue(8'hC5, 8'h35, 1'b0, 1'b0);
    issue(8'hA4, 8'hA7, 1'b0, 1'b0);
    issue(8'h5A, 8'h5A, 1'b0, 1'b0);
    issue(8'h00, 8'hFF, 1'b0, 1'b1);
    issue(8'hFF, 8'hFF, 1'b0, 1'b0);
    issue(8'h00, 8'h00, 1'b0, 1'b1);
    issue(8'hFF, 8'h00, 1'b0, 1'b0);
    wait_idle();
    @(negedge clk);

    // Reset mid-COMPARE: no prediction pushed, so any done would be unexpected.
    a_in  = 8'h12;
    b_in  = 8'h13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(8'h12, 8'h13, 1'b0, 1'b0);

    // Random pulsed starts with random perturbation during COMPARE.
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 1) == 1) ? (a ^ int'($urandom_range(0, 15))) : int'($urandom_range(0, 255));
      issue(a, b, 1'b0, bit'($urandom_range(0, 1)));
    end

    // Back-to-back with start held high.
    for (int i = 0; i < 1500; i++) begin
      a = int'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ int'($urandom_range(0, 3));
        2: b = a ^ int'($urandom_range(0, 63));
        default: b = int'($urandom_range(0, 255));
      endcase
      issue(a, b, 1'b1, 1'b0);
    end
    start = 1'b0;

    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
